eth_tx_scheduler: RTL and testbench
===================================

# eth_tx_scheduler

Round-robin frame scheduler that shares one Tx_Eth100_Sync MII transmitter between N_SRC frame sources. It grants one source at a time and drives the transmitter's request/data handshake for exactly the programmed byte count. It then waits for the transmitter to finish the CRC and enforces the inter-frame gap before the next grant. It sits between the packet-shaping sources (UDP/ARP/status builders) and the transmitter, all on System_Clock.

## Interface
- N_SRC, 4: number of requesting sources (2..8).
- LEN_W, 11: frame length width in bytes.
- MAX_LEN, 1514: largest legal Src_Len (header + payload, no CRC).
- MIN_LEN, 60: padded minimum length (used only with padding compiled in).
- IFG_NIBBLES, 24: inter-frame gap in MII nibble clocks (96 bit times).

Ports:
- System_Clock  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Src_Req  in  N_SRC  per-source frame request, level, held until Src_Done.
- Src_Len  in  N_SRC*LEN_W  per-source frame length, stable while Src_Req is high.
- Src_Data  in  N_SRC*8  per-source current byte; a source advances it on its Src_Byte_Strob.
- Src_Grant  out  N_SRC  one-hot grant, held for the whole frame.
- Src_Byte_Strob  out  N_SRC  1-cycle pulse: byte consumed.
- Src_Done  out  N_SRC  1-cycle pulse: frame finished or rejected.
- Len_Err  out  1  1-cycle pulse together with Src_Done when a length is rejected.
- Transmit_of_Data_RQ  out  1  to transmitter.
- Data_to_Transmit  out  8  to transmitter.
- Byte_Readed_Strob  in  1  from transmitter.
- Eth_Tx_In_Progress  in  1  from transmitter.
- TxClk_Edge_at_System_Clock  in  1  from transmitter; one pulse per MII nibble clock.
- Sched_Busy  out  1  high in every state except IDLE.
- Active_Src  out  3  index of the granted source, or of the last granted source when idle.

## Operation
- **States:** IDLE, LOAD, SEND, DRAIN, IFG.
- **IDLE:**
  - Search Src_Req starting at rr_ptr+1 (mod N_SRC); the first set bit wins.
  - Latch its index and Src_Len, then go to LOAD.
- **LOAD:**
  - Src_Len == 0 or Src_Len > MAX_LEN: pulse Src_Done[idx] and Len_Err, set rr_ptr = idx, return to IDLE. No grant is issued and RQ is not asserted.
  - Otherwise: set Src_Grant[idx], set remaining = effective length, set Transmit_of_Data_RQ, go to SEND.
- **SEND:**
  - Data_to_Transmit = Src_Data[idx], combinational mux.
  - Each Byte_Readed_Strob: Src_Byte_Strob[idx] pulses in the same cycle (combinational gating) and remaining decrements.
  - On the strobe that takes remaining from 1 to 0, Transmit_of_Data_RQ clears at the next clock edge. Go to DRAIN.
- **DRAIN:**
  - Wait for Eth_Tx_In_Progress to be low, sampled registered.
  - Then clear Src_Grant, pulse Src_Done[idx], set rr_ptr = idx, clear the gap counter, go to IFG.
- **IFG:** count TxClk_Edge_at_System_Clock pulses; at IFG_NIBBLES go to IDLE.
- **Requester behaviour:** Src_Req is ignored after grant. Dropping it mid-frame does not abort the frame. Byte strobes continue until the count is exhausted.
- **Stray strobes:** Byte_Readed_Strob outside SEND is ignored and never forwarded.
- **Arbitration fairness:** rr_ptr advances only on Done, so a source that was just served has lowest priority.
- **Simultaneous requests:** resolved purely by the round-robin order.
- **Reset mid-frame:** all outputs go to 0 immediately and the FSM goes to IDLE. The transmitter completes or aborts on its own; no handshake is owed to the source.

## Timing
- Reset values: Src_Grant, Src_Byte_Strob, Src_Done, Len_Err, Transmit_of_Data_RQ, Sched_Busy = 0; Data_to_Transmit = 0x00; Active_Src = 0; rr_ptr = N_SRC-1, so source 0 wins first.
- Src_Req seen in IDLE: grant and RQ rise 2 clocks later (IDLE→LOAD→SEND).
- Data_to_Transmit must be valid before each strobe. The source updates its byte on the clock after Src_Byte_Strob.
- Gap: at least IFG_NIBBLES TxClk edges from the fall of Eth_Tx_In_Progress to the next RQ rise.
- remaining is LEN_W bits wide and must not underflow. Strobes arriving at remaining == 0 are ignored.

## Configuration
- TX_SCHED_PAD_EN defined:
  - Effective length = max(Src_Len, MIN_LEN).
  - Bytes beyond Src_Len are sent as 0x00 with no Src_Byte_Strob pulse.
- Macro absent:
  - Effective length = Src_Len; short frames go out unpadded.
  - MIN_LEN is unused.

## Structure
- Shared package eth_tx_pkg holds:
  - the state encoding constants (one-hot, 5 bits);
  - the default MAX_LEN, MIN_LEN and IFG_NIBBLES constants;
  - the LEN_W default.
- One sub-module: rr_arbiter (N_SRC request vector, pointer input, one-hot grant plus index output, purely combinational). The FSM, counters and data mux stay in eth_tx_scheduler.

## Test plan
- **Single source:** Src_Req[0] with Src_Len = 64, bench transmitter model strobing 64 times.
  - 64 Src_Byte_Strob[0]; RQ drops after the 64th strobe; one Src_Done[0] after In_Progress falls.
- **Simultaneous requests:** Src_Req = 4'b1111 held.
  - Grant order 0,1,2,3,0.
  - ≥24 TxClk edges between each In_Progress fall and the next RQ.
- **Illegal lengths:** Src_Len = 0, then Src_Len = 1600.
  - Src_Done + Len_Err in LOAD, no RQ, no grant; the next source is served.
- **Padding, with TX_SCHED_PAD_EN:** Src_Len = 20.
  - 60 transmitter strobes, 20 Src_Byte_Strob, bytes 21..60 = 0x00.
- **Padding, macro absent:** Src_Len = 20.
  - 20 strobes total.
- **Reset mid-frame:** Reset_n low during SEND after 10 bytes.
  - All outputs 0 within the reset assertion; after release Src_Req[2] is granted first with rr_ptr back to N_SRC-1.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg - shared definitions for the Ethernet transmit scheduler slice.
//   * one-hot FSM state encoding (5 bits)
//   * default frame-length width and length/gap limits
//   * width of the Active_Src status output
package eth_tx_pkg;

    localparam int LEN_W_DEF       = 11;    // frame length width in bytes
    localparam int MAX_LEN_DEF     = 1514;  // header + payload, CRC excluded
    localparam int MIN_LEN_DEF     = 60;    // padded minimum frame length
    localparam int IFG_NIBBLES_DEF = 24;    // 96 bit times at 4 bits per MII clock
    localparam int ACT_SRC_W       = 3;     // enough for up to 8 sources

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_SEND  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_IFG   = 5'b10000
    } sched_state_e;

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// eth_tx_if - request/data handshake between the frame scheduler and the
// Tx_Eth100_Sync MII transmitter.
//   Transmit_of_Data_RQ         scheduler -> transmitter, frame data pending
//   Data_to_Transmit[7:0]       scheduler -> transmitter, current byte
//   Byte_Readed_Strob           transmitter -> scheduler, byte consumed
//   Eth_Tx_In_Progress          transmitter -> scheduler, frame/CRC on the wire
//   TxClk_Edge_at_System_Clock  transmitter -> scheduler, one pulse per nibble clock
// Modports: master = scheduler side, slave = transmitter side.
interface eth_tx_if;

    logic       Transmit_of_Data_RQ;
    logic [7:0] Data_to_Transmit;
    logic       Byte_Readed_Strob;
    logic       Eth_Tx_In_Progress;
    logic       TxClk_Edge_at_System_Clock;

    modport master (
        output Transmit_of_Data_RQ,
        output Data_to_Transmit,
        input  Byte_Readed_Strob,
        input  Eth_Tx_In_Progress,
        input  TxClk_Edge_at_System_Clock
    );

    modport slave (
        input  Transmit_of_Data_RQ,
        input  Data_to_Transmit,
        output Byte_Readed_Strob,
        output Eth_Tx_In_Progress,
        output TxClk_Edge_at_System_Clock
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter - purely combinational round-robin pick.
//   req[N_SRC]  request vector
//   ptr         index of the source served last (lowest priority)
//   gnt[N_SRC]  one-hot winner, zero when nothing requests
//   idx         binary index of the winner
//   any         at least one request present
// The search starts at ptr+1 and wraps, so the source served last comes last.
module rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // First pass: sources above ptr, in ascending order.
        for (int i = 0; i < N_SRC; i++) begin
            if (!any && req[i] && (IDX_W'(i) > ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        // Second pass: wrap around to sources at or below ptr.
        for (int i = 0; i < N_SRC; i++) begin
            if (!any && req[i] && (IDX_W'(i) <= ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler - round-robin frame scheduler sharing one MII transmitter
// between N_SRC frame sources, all on System_Clock.
//
// Ports:
//   System_Clock, Reset_n (async, active low)
//   Src_Req[N_SRC]          level request per source, held until Src_Done
//   Src_Len[N_SRC*LEN_W]    frame length per source (bytes, no CRC)
//   Src_Data[N_SRC*8]       current byte per source
//   Src_Grant[N_SRC]        one-hot grant for the whole frame
//   Src_Byte_Strob[N_SRC]   byte consumed (combinational from the transmitter strobe)
//   Src_Done[N_SRC]         frame finished or length rejected
//   Len_Err                 accompanies Src_Done on a rejected length
//   tx                      eth_tx_if.master handshake to the transmitter
//   Sched_Busy              FSM outside IDLE
//   Active_Src              index of the current / last latched source
//
// Build option: TX_SCHED_PAD_EN pads short frames to MIN_LEN with 0x00 bytes
// that are not strobed back to the source.
module eth_tx_scheduler
    import eth_tx_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int MAX_LEN     = MAX_LEN_DEF,
    parameter int MIN_LEN     = MIN_LEN_DEF,
    parameter int IFG_NIBBLES = IFG_NIBBLES_DEF
) (
    input  logic                   System_Clock,
    input  logic                   Reset_n,
    input  logic [N_SRC-1:0]       Src_Req,
    input  logic [N_SRC*LEN_W-1:0] Src_Len,
    input  logic [N_SRC*8-1:0]     Src_Data,
    output logic [N_SRC-1:0]       Src_Grant,
    output logic [N_SRC-1:0]       Src_Byte_Strob,
    output logic [N_SRC-1:0]       Src_Done,
    output logic                   Len_Err,
    eth_tx_if.master               tx,
    output logic                   Sched_Busy,
    output logic [ACT_SRC_W-1:0]   Active_Src
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int GAP_W = $clog2(IFG_NIBBLES + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] IFG_V     = GAP_W'(IFG_NIBBLES);

    logic [N_SRC-1:0][LEN_W-1:0] len_v;
    logic [N_SRC-1:0][7:0]       data_v;

    assign len_v  = Src_Len;
    assign data_v = Src_Data;

    sched_state_e     state, state_nx;
    logic [IDX_W-1:0] idx, rr_ptr, arb_idx;
    logic [N_SRC-1:0] arb_gnt, grant_oh;
    logic             arb_any;
    logic [LEN_W-1:0] len_lat, remaining, eff_len;
    logic [GAP_W-1:0] gap_cnt;
    logic             tx_busy_q;
    logic             len_bad;
    logic             byte_take;  // transmitter strobe accepted this cycle
    logic             src_byte;   // current byte comes from the source (not padding)

    rr_arbiter #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_arb (
        .req (Src_Req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign len_bad   = (len_lat == '0) || (len_lat > MAX_LEN_V);
    // remaining != 0 keeps a late strobe from wrapping the counter.
    assign byte_take = (state == ST_SEND) && tx.Byte_Readed_Strob && (remaining != '0);

`ifdef TX_SCHED_PAD_EN
    localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);
    logic [LEN_W-1:0] src_left;  // source bytes still owed before padding starts

    assign eff_len  = (len_lat < MIN_LEN_V) ? MIN_LEN_V : len_lat;
    assign src_byte = (src_left != '0);

    always_ff @(posedge System_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            src_left <= '0;
        end else if (state == ST_LOAD) begin
            src_left <= len_lat;
        end else if (byte_take && src_byte) begin
            src_left <= src_left - LEN_W'(1);
        end
    end
`else
    // MIN_LEN only matters when padding is compiled in.
    logic unused_min_len;
    assign unused_min_len = ^MIN_LEN;
    assign eff_len        = len_lat;
    assign src_byte       = 1'b1;
`endif

    // State register
    always_ff @(posedge System_Clock or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = len_bad ? ST_IDLE : ST_SEND;
            ST_SEND:  if (byte_take && (remaining == LEN_W'(1))) state_nx = ST_DRAIN;
            ST_DRAIN: if (!tx_busy_q) state_nx = ST_IFG;
            ST_IFG:   if (gap_cnt >= IFG_V) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Output logic; everything decodes from registered state so reset
    // forces all outputs low at once.
    always_comb begin
        Src_Grant              = '0;
        Src_Byte_Strob         = '0;
        Src_Done               = '0;
        Len_Err                = 1'b0;
        tx.Transmit_of_Data_RQ = 1'b0;
        tx.Data_to_Transmit    = 8'h00;
        case (state)
            ST_LOAD: begin
                if (len_bad) begin
                    Src_Done = grant_oh;
                    Len_Err  = 1'b1;
                end
            end
            ST_SEND: begin
                Src_Grant              = grant_oh;
                tx.Transmit_of_Data_RQ = 1'b1;
                tx.Data_to_Transmit    = src_byte ? data_v[idx] : 8'h00;
                if (byte_take && src_byte) Src_Byte_Strob = grant_oh;
            end
            ST_DRAIN: begin
                Src_Grant = grant_oh;
                if (!tx_busy_q) Src_Done = grant_oh;
            end
            default: ;
        endcase
    end

    assign Sched_Busy = (state != ST_IDLE);
    assign Active_Src = ACT_SRC_W'(idx);

    // Datapath: latched request, byte countdown, gap counter, rr pointer.
    always_ff @(posedge System_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            idx       <= '0;
            grant_oh  <= '0;
            rr_ptr    <= IDX_W'(N_SRC - 1);  // source 0 wins first
            len_lat   <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            tx_busy_q <= tx.Eth_Tx_In_Progress;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        idx      <= arb_idx;
                        grant_oh <= arb_gnt;
                        len_lat  <= len_v[arb_idx];
                    end
                end
                ST_LOAD: begin
                    if (len_bad) rr_ptr    <= idx;
                    else         remaining <= eff_len;
                end
                ST_SEND: begin
                    if (byte_take) remaining <= remaining - LEN_W'(1);
                end
                ST_DRAIN: begin
                    if (!tx_busy_q) begin
                        rr_ptr  <= idx;
                        gap_cnt <= '0;
                    end
                end
                ST_IFG: begin
                    if (tx.TxClk_Edge_at_System_Clock && (gap_cnt < IFG_V))
                        gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler with a behavioural transmitter and
// four byte-pattern sources.
module tb_eth_tx_scheduler;

    logic             System_Clock;
    logic             Reset_n;
    logic [3:0]       Src_Req;
    logic [3:0][10:0] src_len;
    logic [3:0][7:0]  src_data;
    logic [3:0]       Src_Grant, Src_Byte_Strob, Src_Done;
    logic             Len_Err, Sched_Busy;
    logic [2:0]       Active_Src;

    eth_tx_if tx();

    eth_tx_scheduler dut (
        .System_Clock   (System_Clock),
        .Reset_n        (Reset_n),
        .Src_Req        (Src_Req),
        .Src_Len        (src_len),
        .Src_Data       (src_data),
        .Src_Grant      (Src_Grant),
        .Src_Byte_Strob (Src_Byte_Strob),
        .Src_Done       (Src_Done),
        .Len_Err        (Len_Err),
        .tx             (tx),
        .Sched_Busy     (Sched_Busy),
        .Active_Src     (Active_Src)
    );

    int n_asrt = 0;
    int n_fail = 0;
    int fwd_cnt, bad_cnt;
    int edge_cnt = 0;
    int fall_edges = 0;
    bit have_fall = 0;
    int bcnt [4];

    initial begin
        System_Clock = 1'b0;
        forever #5 System_Clock = ~System_Clock;
    end

    // One nibble-clock pulse every 4 system clocks.
    initial begin
        tx.TxClk_Edge_at_System_Clock = 1'b0;
        forever begin
            repeat (3) @(negedge System_Clock);
            tx.TxClk_Edge_at_System_Clock = 1'b1;
            @(negedge System_Clock);
            tx.TxClk_Edge_at_System_Clock = 1'b0;
        end
    end

    always @(posedge System_Clock)
        if (tx.TxClk_Edge_at_System_Clock) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] pat(input int s, input int k);
        return 8'((s * 37 + k * 5 + 1) & 255);
    endfunction

    function automatic logic [3:0] onehot(input int s);
        return 4'(1 << s);
    endfunction

    function automatic int eff(input int l);
`ifdef TX_SCHED_PAD_EN
        return (l < 60) ? 60 : l;
`else
        return l;
`endif
    endfunction

    // Source model: byte index advances on the clock after each strobe.
    always @(posedge System_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < 4; s++) bcnt[s] <= 0;
        end else begin
            for (int s = 0; s < 4; s++)
                if (Src_Done[s])            bcnt[s] <= 0;
                else if (Src_Byte_Strob[s]) bcnt[s] <= bcnt[s] + 1;
        end
    end

    always_comb begin
        src_data = '0;
        for (int s = 0; s < 4; s++) src_data[s] = pat(s, bcnt[s]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 400 && Sched_Busy; w++) @(negedge System_Clock);
        chk("sched_idle", 32'(Sched_Busy), 32'd0);
    endtask

    // Transmitter reads n bytes, one strobe every other clock.
    task automatic xfer(input int src, input int len, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge System_Clock);
            tx.Byte_Readed_Strob = 1'b1;
            #1;
            if (!tx.Transmit_of_Data_RQ) bad_cnt++;
            if (tx.Data_to_Transmit !== ((k < len) ? pat(src, k) : 8'h00)) bad_cnt++;
            if (Src_Byte_Strob[src]) fwd_cnt++;
            if ((Src_Byte_Strob & ~onehot(src)) != 4'b0) bad_cnt++;
            @(negedge System_Clock);
            tx.Byte_Readed_Strob = 1'b0;
        end
    endtask

    // Full frame from RQ rise to Src_Done.
    task automatic serve(input int src, input int len);
        int early;
        for (int w = 0; w < 400 && !tx.Transmit_of_Data_RQ; w++) @(negedge System_Clock);
        chk($sformatf("rq_rise_s%0d", src), 32'(tx.Transmit_of_Data_RQ), 32'd1);
        if (have_fall)
            chk($sformatf("ifg_ge24_s%0d", src), 32'(edge_cnt - fall_edges >= 24), 32'd1);
        chk($sformatf("grant_s%0d", src), 32'(Src_Grant), 32'(onehot(src)));
        chk($sformatf("active_src_s%0d", src), 32'(Active_Src), 32'(src));
        tx.Eth_Tx_In_Progress = 1'b1;
        fwd_cnt = 0;
        bad_cnt = 0;
        xfer(src, len, eff(len));
        chk($sformatf("fwd_strobes_s%0d", src), 32'(fwd_cnt), 32'(len));
        chk($sformatf("xfer_errs_s%0d", src), 32'(bad_cnt), 32'd0);
        #1;
        chk($sformatf("rq_drop_s%0d", src), 32'(tx.Transmit_of_Data_RQ), 32'd0);
        // Stray strobe while draining must not reach the source.
        tx.Byte_Readed_Strob = 1'b1;
        #1;
        chk("stray_fwd_drain", 32'(Src_Byte_Strob), 32'd0);
        @(negedge System_Clock);
        tx.Byte_Readed_Strob = 1'b0;
        early = 0;
        repeat (3) begin
            @(negedge System_Clock);
            if (Src_Done != 4'b0) early++;
        end
        chk($sformatf("done_before_fall_s%0d", src), 32'(early), 32'd0);
        tx.Eth_Tx_In_Progress = 1'b0;
        fall_edges = edge_cnt;
        have_fall  = 1'b1;
        for (int w = 0; w < 10; w++) begin
            @(negedge System_Clock);
            if (Src_Done != 4'b0) break;
        end
        chk($sformatf("done_s%0d", src), 32'(Src_Done), 32'(onehot(src)));
        chk($sformatf("len_err_clr_s%0d", src), 32'(Len_Err), 32'd0);
        @(negedge System_Clock);
        chk($sformatf("done_1cyc_s%0d", src), 32'(Src_Done), 32'd0);
        chk($sformatf("grant_rel_s%0d", src), 32'(Src_Grant), 32'd0);
        chk($sformatf("busy_ifg_s%0d", src), 32'(Sched_Busy), 32'd1);
    endtask

    initial begin
        Reset_n                = 1'b0;
        Src_Req                = 4'b0;
        src_len                = '0;
        tx.Byte_Readed_Strob   = 1'b0;
        tx.Eth_Tx_In_Progress  = 1'b0;
        repeat (3) @(negedge System_Clock);
        #1;
        chk("rst_grant", 32'(Src_Grant), 32'd0);
        chk("rst_bstrb", 32'(Src_Byte_Strob), 32'd0);
        chk("rst_done", 32'(Src_Done), 32'd0);
        chk("rst_len_err", 32'(Len_Err), 32'd0);
        chk("rst_rq", 32'(tx.Transmit_of_Data_RQ), 32'd0);
        chk("rst_busy", 32'(Sched_Busy), 32'd0);
        chk("rst_data", 32'(tx.Data_to_Transmit), 32'd0);
        chk("rst_active", 32'(Active_Src), 32'd0);
        @(negedge System_Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge System_Clock);

        // Simultaneous requests: 0,1,2,3,0 and 2-clock grant latency.
        src_len[0] = 11'd8;
        src_len[1] = 11'd5;
        src_len[2] = 11'd6;
        src_len[3] = 11'd7;
        Src_Req = 4'b1111;
        @(negedge System_Clock);
        chk("lat_load_rq", 32'(tx.Transmit_of_Data_RQ), 32'd0);
        chk("lat_load_busy", 32'(Sched_Busy), 32'd1);
        @(negedge System_Clock);
        chk("lat_send_rq", 32'(tx.Transmit_of_Data_RQ), 32'd1);
        serve(0, 8);
        serve(1, 5);
        serve(2, 6);
        serve(3, 7);
        serve(0, 8);
        Src_Req = 4'b0;

        // Single source, 64 bytes, with a stray strobe while idle first.
        wait_idle();
        @(negedge System_Clock);
        tx.Byte_Readed_Strob = 1'b1;
        #1;
        chk("stray_fwd_idle", 32'(Src_Byte_Strob), 32'd0);
        chk("stray_data_idle", 32'(tx.Data_to_Transmit), 32'd0);
        @(negedge System_Clock);
        tx.Byte_Readed_Strob = 1'b0;
        src_len[0] = 11'd64;
        Src_Req = 4'b0001;
        serve(0, 64);
        Src_Req = 4'b0;

        // Illegal lengths on sources 1 and 2; source 3 is served next.
        wait_idle();
        src_len[1] = 11'd0;
        src_len[2] = 11'd1600;
        src_len[3] = 11'd16;
        Src_Req = 4'b1110;
        @(negedge System_Clock);
        chk("zero_len_done", 32'(Src_Done), 32'b0010);
        chk("zero_len_err", 32'(Len_Err), 32'd1);
        chk("zero_len_rq", 32'(tx.Transmit_of_Data_RQ), 32'd0);
        chk("zero_len_grant", 32'(Src_Grant), 32'd0);
        Src_Req[1] = 1'b0;
        @(negedge System_Clock);
        chk("rej_gap_done", 32'(Src_Done), 32'd0);
        chk("rej_gap_err", 32'(Len_Err), 32'd0);
        @(negedge System_Clock);
        chk("long_len_done", 32'(Src_Done), 32'b0100);
        chk("long_len_err", 32'(Len_Err), 32'd1);
        chk("long_len_rq", 32'(tx.Transmit_of_Data_RQ), 32'd0);
        chk("long_len_grant", 32'(Src_Grant), 32'd0);
        Src_Req[2] = 1'b0;
        serve(3, 16);
        Src_Req = 4'b0;

        // Short frame: padded to 60 only when padding is compiled in.
        wait_idle();
        src_len[0] = 11'd20;
        Src_Req = 4'b0001;
        serve(0, 20);
        Src_Req = 4'b0;

        // Reset after 10 bytes of a source-2 frame.
        wait_idle();
        src_len[2] = 11'd40;
        Src_Req = 4'b0100;
        for (int w = 0; w < 400 && !tx.Transmit_of_Data_RQ; w++) @(negedge System_Clock);
        chk("pre_rst_grant", 32'(Src_Grant), 32'b0100);
        tx.Eth_Tx_In_Progress = 1'b1;
        fwd_cnt = 0;
        bad_cnt = 0;
        xfer(2, 40, 10);
        chk("pre_rst_fwd", 32'(fwd_cnt), 32'd10);
        Reset_n = 1'b0;
        tx.Eth_Tx_In_Progress = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(Src_Grant), 32'd0);
        chk("mid_rst_rq", 32'(tx.Transmit_of_Data_RQ), 32'd0);
        chk("mid_rst_data", 32'(tx.Data_to_Transmit), 32'd0);
        chk("mid_rst_busy", 32'(Sched_Busy), 32'd0);
        chk("mid_rst_active", 32'(Active_Src), 32'd0);
        chk("mid_rst_done", 32'(Src_Done), 32'd0);
        repeat (2) @(negedge System_Clock);
        Reset_n   = 1'b1;
        have_fall = 1'b0;
        @(negedge System_Clock);
        chk("post_rst_load_rq", 32'(tx.Transmit_of_Data_RQ), 32'd0);
        @(negedge System_Clock);
        chk("post_rst_rq", 32'(tx.Transmit_of_Data_RQ), 32'd1);
        serve(2, 40);
        Src_Req = 4'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
